booth_mult_seq: RTL and testbench

//  Parametrised sequential radix-2 Booth multiplier for the UART calculator datapath.

---
 rtl/booth_mult_seq_if.sv | 31 +++
 rtl/booth_mult_seq.sv | 119 +++++++++++
 tb/tb_booth_mult_seq.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/booth_mult_seq_if.sv
// Operand/result bundle between the calculator parser (master) and booth_mult_seq (slave).
// is_signed exists only when BOOTH_UNSIGNED_EN is defined.
interface booth_mult_seq_if #(
  parameter int WIDTH = 16
);
  logic               start;
  logic               abort;
  logic [WIDTH-1:0]   src1;
  logic [WIDTH-1:0]   src2;
`ifdef BOOTH_UNSIGNED_EN
  logic               is_signed;
`endif
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] calc_res;

  // Handshake: start is a level request accepted only while idle and abort is low;
  // busy covers the whole operation; done is a one-cycle pulse, and calc_res is valid
  // from that pulse until the next one. abort cancels silently (no done).
`ifdef BOOTH_UNSIGNED_EN
  modport master (output start, abort, src1, src2, is_signed,
                  input  busy, done, calc_res);
  modport slave  (input  start, abort, src1, src2, is_signed,
                  output busy, done, calc_res);
`else
  modport master (output start, abort, src1, src2,
                  input  busy, done, calc_res);
  modport slave  (input  start, abort, src1, src2,
                  output busy, done, calc_res);
`endif
endinterface

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, one step per clock, WIDTH-bit operands -> 2*WIDTH product.
// Optional feature macro: BOOTH_UNSIGNED_EN (adds is_signed and one extra step for unsigned operands).
module booth_mult_seq #(
  parameter int WIDTH = 16
) (
  input  logic            clk,
  input  logic            n_rst,
  booth_mult_seq_if.slave bus,
  output logic [1:0]      dbg_state
);

`ifdef BOOTH_UNSIGNED_EN
  // Q carries an extension bit so both modes run as (WIDTH+1)-bit signed Booth.
  localparam int QW = WIDTH + 1;
  localparam int N  = WIDTH + 1;
`else
  localparam int QW = WIDTH;
  localparam int N  = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH:0]     a_q, a_d;
  logic [WIDTH:0]     m_q, m_d;
  logic [QW-1:0]      q_q, q_d;
  logic               qm1_q, qm1_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic [WIDTH:0]     sum;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    m_d     = m_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    res_d   = res_q;
    sum     = a_q;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
`ifdef BOOTH_UNSIGNED_EN
          m_d = {bus.is_signed & bus.src1[WIDTH-1], bus.src1};
          q_d = {bus.is_signed & bus.src2[WIDTH-1], bus.src2};
`else
          m_d = {bus.src1[WIDTH-1], bus.src1};
          q_d = bus.src2;
`endif
          a_d     = '0;
          qm1_d   = 1'b0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          case ({q_q[0], qm1_q})
            2'b10:   sum = a_q - m_q;
            2'b01:   sum = a_q + m_q;
            default: sum = a_q;
          endcase
          // Arithmetic right shift of {A,Q,q_m1} by one.
          a_d   = {sum[WIDTH], sum[WIDTH:1]};
          q_d   = {sum[0], q_q[QW-1:1]};
          qm1_d = q_q[0];
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!bus.abort) begin
          done_d = 1'b1;
          res_d  = {a_q[2*WIDTH-QW-1:0], q_q};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.calc_res = res_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq (WIDTH=16): driver tasks push expected products,
// an independent monitor pops and compares them (value and latency) on every done pulse.
module tb_booth_mult_seq;
  localparam int WIDTH = 16;
`ifdef BOOTH_UNSIGNED_EN
  localparam int LAT = WIDTH + 2;
`else
  localparam int LAT = WIDTH + 1;
`endif

  logic        clk;
  logic        n_rst;
  logic [1:0]  dbg_state;
  logic        drv_sgn;
  int          cyc;
  int          n_checks;
  int          n_pass;

  logic [2*WIDTH-1:0] exp_q[$];
  int                 cap_q[$];

  booth_mult_seq_if #(.WIDTH(WIDTH)) bus ();

`ifdef BOOTH_UNSIGNED_EN
  assign bus.is_signed = drv_sgn;
`endif

  booth_mult_seq #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (n_rst && bus.done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(bus.done), 64'(0));
      end else begin
        logic [2*WIDTH-1:0] e;
        int c;
        e = exp_q.pop_front();
        c = cap_q.pop_front();
        check("product", 64'(bus.calc_res), 64'(e));
        check("latency", 64'(cyc - c), 64'(LAT));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic sgn);
    @(negedge clk);
    bus.src1  = a;
    bus.src2  = b;
    drv_sgn   = sgn;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < LAT + 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1;
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL %s_timeout: got no done, expected done within %0d cycles", name, LAT + 10);
    end
  endtask

  task automatic run_op(input string name, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic sgn,
                        input logic [2*WIDTH-1:0] e);
    issue(a, b, sgn);
    exp_q.push_back(e);
    cap_q.push_back(cyc);
    wait_done(name);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c0;
    logic [2*WIDTH-1:0] held;
    n_checks  = 0;
    n_pass    = 0;
    cyc       = 0;
    n_rst     = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.src1  = '0;
    bus.src2  = '0;
    drv_sgn   = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_res",  64'(bus.calc_res), 64'(0));
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    // Basic product and busy right after capture.
    issue(16'd3, 16'd5, 1'b1);
    exp_q.push_back(32'h0000_000F);
    cap_q.push_back(cyc);
    check("busy_after_start", 64'(bus.busy), 64'(1));
    wait_done("op_3x5");

    run_op("op_m7x6",     16'hFFF9, 16'd6,    1'b1, 32'hFFFF_FFD6);
    run_op("op_min_min",  16'h8000, 16'h8000, 1'b1, 32'h4000_0000);
    run_op("op_max_min",  16'h7FFF, 16'h8000, 1'b1, 32'hC000_8000);
    run_op("op_zero",     16'h0000, 16'h1234, 1'b1, 32'h0000_0000);

    // Operands changed mid-CALC with start held; second op captured right after done.
    @(negedge clk);
    bus.src1  = 16'd4;
    bus.src2  = 16'd3;
    drv_sgn   = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    c0 = cyc;
    exp_q.push_back(32'd12);
    cap_q.push_back(c0);
    exp_q.push_back(32'd36);
    cap_q.push_back(c0 + LAT + 1);
    repeat (3) @(negedge clk);
    bus.src2 = 16'd9;
    wait_done("op_held_first");
    @(posedge clk);
    #1;
    check("b2b_capture_busy", 64'(bus.busy), 64'(1));
    bus.start = 1'b0;
    wait_done("op_held_second");
    held = 32'd36;

    // Abort five cycles into CALC.
    issue(16'd100, 16'd100, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    check("abort_calc_idle", 64'(bus.busy), 64'(0));
    repeat (LAT + 3) @(negedge clk);
    check("abort_calc_res", 64'(bus.calc_res), 64'(held));

    // Abort while in DONE.
    issue(16'd7, 16'd7, 1'b1);
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
    check("done_state_busy", 64'(bus.busy), 64'(1));
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    check("abort_done_idle", 64'(bus.busy), 64'(0));
    repeat (4) @(negedge clk);
    check("abort_done_res", 64'(bus.calc_res), 64'(held));

    // abort and start together in IDLE: nothing captured.
    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("abort_start_busy", 64'(bus.busy), 64'(0));

    // Asynchronous reset mid-CALC, then a clean restart.
    issue(16'd11, 16'd13, 1'b1);
    repeat (5) @(posedge clk);
    #3;
    n_rst = 1'b0;
    #1;
    check("arst_busy", 64'(bus.busy), 64'(0));
    check("arst_done", 64'(bus.done), 64'(0));
    check("arst_res",  64'(bus.calc_res), 64'(0));
    @(negedge clk);
    n_rst = 1'b1;
    run_op("op_after_rst", 16'hFFF9, 16'd6, 1'b1, 32'hFFFF_FFD6);

`ifdef BOOTH_UNSIGNED_EN
    run_op("op_u_ffff", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001);
    run_op("op_u_mix",  16'h8000, 16'd2,    1'b0, 32'h0001_0000);
`endif
    run_op("op_s_ffff", 16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001);

    repeat (5) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
